// File: rtl/jtframe_mist_dwnld_pkg.sv
// jtframe_mist_pkg: command codes and FSM state type shared by the MiST download receiver
package jtframe_mist_pkg;

   localparam logic [7:0] CMD_FILE_TX  = 8'h53;
   localparam logic [7:0] CMD_FILE_DAT = 8'h54;
   localparam logic [7:0] CMD_FILE_IDX = 8'h55;

   typedef enum logic [2:0] {IDLE, CMD, INDEX, TXCTL, DATA, SKIP} state_t;

   // Maps the first byte of a frame to the state that consumes its payload
   function automatic state_t decode_cmd(input logic [7:0] c);
      return c == CMD_FILE_IDX ? INDEX :
             c == CMD_FILE_TX  ? TXCTL :
             c == CMD_FILE_DAT ? DATA  : SKIP;
   endfunction

endpackage

// File: rtl/jtframe_mist_dwnld_if.sv
// jtframe_mist_dwnld_if: ioctl download bus from the SPI receiver to the SDRAM loader
interface jtframe_mist_dwnld_if #(parameter int AW = 25);

   logic [7:0]    ioctl_index;
   logic [AW-1:0] ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic          ioctl_wr;
   logic          downloading;
   logic          ovf;

   modport master(output ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr, downloading, ovf);
   modport slave (input  ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr, downloading, ovf);

endinterface

// File: rtl/jtframe_mist_dwnld_spi_rx.sv
// jtframe_spi_rx: synchronises the SPI pins and assembles MSB-first bytes within SS2-low frames
module jtframe_spi_rx #(parameter int SYNC = 2) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       ss,
   input  logic       di,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_start,
   output logic       frame_end
);

   logic [SYNC-1:0] sck_s, ss_s, di_s;
   logic            sck_d, ss_d, sck_rise;
   logic [6:0]      sr;
   logic [2:0]      bit_cnt;

   // Sync flops reset to 0 so a frame already in progress at reset release gives no start edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_s   <= '0;
         ss_s    <= '0;
         di_s    <= '0;
         sck_d   <= 1'b0;
         ss_d    <= 1'b0;
         sr      <= '0;
         bit_cnt <= '0;
      end else begin
         sck_s <= {sck_s[SYNC-2:0], sck};
         ss_s  <= {ss_s[SYNC-2:0], ss};
         di_s  <= {di_s[SYNC-2:0], di};
         sck_d <= sck_s[SYNC-1];
         ss_d  <= ss_s[SYNC-1];
         if (ss_s[SYNC-1]) bit_cnt <= '0;
         else if (sck_rise) begin
            sr      <= {sr[5:0], di_s[SYNC-1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

   // The completing bit is merged combinationally so the byte reaches the FSM one clk earlier
   always_comb begin
      sck_rise    = sck_s[SYNC-1] & ~sck_d & ~ss_s[SYNC-1];
      byte_valid  = sck_rise & (bit_cnt == 3'd7);
      rx_byte     = {sr, di_s[SYNC-1]};
      frame_start = ~ss_s[SYNC-1] & ss_d;
      frame_end   = ss_s[SYNC-1] & ~ss_d;
   end

endmodule

// File: rtl/jtframe_mist_dwnld.sv
// jtframe_mist_dwnld: MiST SPI file-transfer receiver driving the ioctl download bus
module jtframe_mist_dwnld
   import jtframe_mist_pkg::*;
#(
   parameter int AW   = 25,
   parameter int SYNC = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic SPI_SCK,
   input  logic SPI_SS2,
   input  logic SPI_DI,
   jtframe_mist_dwnld_if.master io
);

   logic        byte_valid, frame_start, frame_end;
   logic [7:0]  rx_byte;
   logic [AW:0] cnt;
   state_t      st;

   jtframe_spi_rx #(.SYNC(SYNC)) u_rx (
      .clk         (clk),
      .rst         (rst),
      .sck         (SPI_SCK),
      .ss          (SPI_SS2),
      .di          (SPI_DI),
      .byte_valid  (byte_valid),
      .rx_byte     (rx_byte),
      .frame_start (frame_start),
      .frame_end   (frame_end)
   );

   // Command FSM; cnt carries one extra bit so passing all-ones is seen as overflow instead of a wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st             <= IDLE;
         cnt            <= '0;
         io.ioctl_index <= '0;
         io.ioctl_addr  <= '0;
         io.ioctl_dout  <= '0;
         io.ioctl_wr    <= 1'b0;
         io.downloading <= 1'b0;
         io.ovf         <= 1'b0;
      end else begin
         io.ioctl_wr <= 1'b0;
         if (frame_end) st <= IDLE;
         else if (frame_start) st <= CMD;
         else if (byte_valid) begin
            case (st)
               CMD:   st <= decode_cmd(rx_byte);
               INDEX: io.ioctl_index <= rx_byte;
               TXCTL: begin
                  io.downloading <= |rx_byte;
                  if (|rx_byte) begin
                     cnt    <= '0;
                     io.ovf <= 1'b0;
                  end
               end
               DATA: if (io.downloading) begin
                  if (cnt[AW]) io.ovf <= 1'b1;
                  else begin
                     io.ioctl_addr <= cnt[AW-1:0];
                     io.ioctl_dout <= rx_byte;
                     io.ioctl_wr   <= 1'b1;
                     cnt           <= cnt + (AW+1)'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtframe_mist_dwnld.sv
`timescale 1ns/1ps
// tb_jtframe_mist_dwnld: SPI frames to two receivers (AW=25/SYNC=2, AW=4/SYNC=3) checked against a byte-level model
module tb_jtframe_mist_dwnld;

   logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ss2 = 1'b1, di = 1'b0;
   int   n_checks = 0, n_err = 0;

   jtframe_mist_dwnld_if #(.AW(25)) ia();
   jtframe_mist_dwnld_if #(.AW(4))  ib();

   jtframe_mist_dwnld #(.AW(25), .SYNC(2)) dut_a (
      .clk(clk), .rst(rst), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di), .io(ia));
   jtframe_mist_dwnld #(.AW(4), .SYNC(3)) dut_b (
      .clk(clk), .rst(rst), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di), .io(ib));

   always #5 clk = ~clk;

   // model of the download channel, one slot per DUT
   int          aw [2] = '{25, 4};
   int          m_cnt [2];
   bit          m_dl [2], m_ovf [2];
   logic [7:0]  m_idx [2], m_dout [2];
   logic [24:0] m_addr [2];
   logic [32:0] exp_q [2][$];
   logic [32:0] got_q [2][$];
   logic [7:0]  fr [$];

   // every strobe is recorded as {addr, dout}
   always @(negedge clk) begin
      if (ia.ioctl_wr) got_q[0].push_back({ia.ioctl_addr, ia.ioctl_dout});
      if (ib.ioctl_wr) got_q[1].push_back({25'(ib.ioctl_addr), ib.ioctl_dout});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_dl[k] = 0; m_ovf[k] = 0;
         m_idx[k] = 0; m_dout[k] = 0; m_addr[k] = 0;
      end
   endtask

   task automatic model_frame(input logic [7:0] b[$]);
      for (int k = 0; k < 2; k++)
         for (int i = 1; i < b.size(); i++)
            case (b[0])
               8'h55: m_idx[k] = b[i];
               8'h53: if (b[i] != 0) begin m_dl[k] = 1; m_cnt[k] = 0; m_ovf[k] = 0; end else m_dl[k] = 0;
               8'h54: if (m_dl[k]) begin
                  if (m_cnt[k] < (1 << aw[k])) begin
                     m_addr[k] = 25'(m_cnt[k]);
                     m_dout[k] = b[i];
                     exp_q[k].push_back({m_addr[k], b[i]});
                     m_cnt[k]++;
                  end else m_ovf[k] = 1;
               end
               default: ;
            endcase
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".a"}, {ia.ioctl_index, ia.ioctl_addr, ia.ioctl_dout, ia.ioctl_wr, ia.downloading, ia.ovf}, 0);
      chk({tag, ".b"}, {ib.ioctl_index, ib.ioctl_addr, ib.ioctl_dout, ib.ioctl_wr, ib.downloading, ib.ovf}, 0);
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         string t = $sformatf("%s.%s", tag, k ? "b" : "a");
         chk({t, ".n_wr"}, got_q[k].size(), exp_q[k].size());
         while (got_q[k].size() > 0 && exp_q[k].size() > 0)
            chk({t, ".wr_addr_dout"}, got_q[k].pop_front(), exp_q[k].pop_front());
         got_q[k].delete();
         exp_q[k].delete();
         chk({t, ".index"}, k ? ib.ioctl_index : ia.ioctl_index, m_idx[k]);
         chk({t, ".downloading"}, k ? ib.downloading : ia.downloading, m_dl[k]);
         chk({t, ".ovf"}, k ? ib.ovf : ia.ovf, m_ovf[k]);
         chk({t, ".addr"}, k ? 25'(ib.ioctl_addr) : ia.ioctl_addr, m_addr[k]);
         chk({t, ".dout"}, k ? ib.ioctl_dout : ia.ioctl_dout, m_dout[k]);
      end
   endtask

   task automatic shift(input logic [7:0] b, input int n, input int h);
      for (int j = 7; j > 7 - n; j--) begin
         di = b[j];
         #(h) sck = 1'b1;
         #(h) sck = 1'b0;
      end
      #(h);
   endtask

   // one SS2-low frame; optional trailing partial byte and optional reset before byte rst_at
   task automatic send(input string tag, input logic [7:0] b[$], input int part = 0, input int rst_at = -1);
      logic [7:0] mb [$];
      bit cut = 0;
      int h = $urandom_range(20, 40);
      ss2 = 1'b0;
      #(3 * h);
      for (int i = 0; i < b.size(); i++) begin
         if (i == rst_at) begin
            #100;
            model_frame(mb);
            mb.delete();
            cut = 1;
            rst = 1'b1;
            #1 check_zero({tag, ".rst_now"});
            #20 rst = 1'b0;
            model_reset();
            #30;
         end
         shift(b[i], 8, h);
         if (!cut) mb.push_back(b[i]);
      end
      if (part > 0) shift(8'($urandom), part, h);
      ss2 = 1'b1;
      #100;
      if (!cut) model_frame(mb);
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #33 check_zero("reset");
      rst = 1'b0;
      #50;
      fr = '{8'h55, 8'h05};                 send("index", fr);
      fr = '{8'h53, 8'hFF};                 send("start", fr);
      chk("dl_rise", ia.downloading, 1'b1);
      fr = '{8'h54, 8'hA0, 8'hA1, 8'hA2};   send("data3", fr);
      fr = '{8'h53, 8'h00};                 send("end", fr);
      chk("dl_fall", ia.downloading, 1'b0);
      fr = '{8'h53, 8'h01};                 send("start2", fr);
      fr = '{8'h54, 8'($urandom), 8'($urandom)}; send("split1", fr);
      fr = '{8'h54, 8'($urandom)};          send("split2", fr);
      fr = '{8'h53, 8'h00};                 send("end2", fr);
      fr = '{8'h54, 8'h77};                 send("idle_data", fr);
      fr = '{8'h53, 8'h3C};                 send("start3", fr);
      fr = '{8'h54, 8'($urandom)};          send("before_part", fr);
      fr = '{8'h54};                        send("partial", fr, 5);
      fr = '{8'h54, 8'h99};                 send("after_part", fr);
      fr = '{8'h53, 8'h80};                 send("start_ovf", fr);
      fr = '{8'h54};
      for (int i = 0; i < 17; i++) fr.push_back(8'($urandom));
      send("ovf17", fr);
      chk("ovf_set", ib.ovf, 1'b1);
      chk("ovf_last_addr", ib.ioctl_addr, 4'hF);
      fr = '{8'h53, 8'h01};                 send("restart", fr);
      chk("ovf_clear", ib.ovf, 1'b0);
      fr = '{8'h54, 8'($urandom)};          send("restart_data", fr);
      fr = '{8'h5A, 8'h54, 8'h12};          send("unknown", fr);
      for (int n = 0; n < 25; n++) begin
         int sel = $urandom_range(0, 4);
         logic [7:0] c = sel == 0 ? 8'h53 : sel == 4 ? 8'($urandom) : sel == 3 ? 8'h55 : 8'h54;
         fr = '{c};
         for (int i = $urandom_range(0, 4); i > 0; i--)
            fr.push_back(c == 8'h53 && $urandom_range(0, 2) == 0 ? 8'h00 : 8'($urandom));
         send($sformatf("rand%0d", n), fr, $urandom_range(0, 1) ? 0 : $urandom_range(1, 7));
      end
      fr = '{8'h53, 8'h01};                 send("start_rst", fr);
      fr = '{8'h54, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      send("rst_mid", fr, 0, 2);
      fr = '{8'h53, 8'h01};                 send("start_after_rst", fr);
      fr = '{8'h54, 8'($urandom)};          send("data_after_rst", fr);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
